// File: rtl/fm_demod_pkg.sv
// Shared constants, fixed-point helpers and FSM state type for the FM discriminator.
package fm_demod_pkg;

    localparam int QUANT_BITS  = 10;
    localparam int QUAD1       = 804;
    localparam int QUAD3       = 2412;
    localparam int FM_GAIN_DEF = 758;

    typedef enum logic [2:0] {
        READ,
        CONJ,
        DIV_START,
        DIV_WAIT,
        ANGLE,
        WRITE
    } fm_demod_state_t;

    function automatic logic signed [63:0] quantize_i(input logic signed [63:0] x);
        return x <<< QUANT_BITS;
    endfunction

    function automatic logic signed [63:0] dequantize_i(input logic signed [63:0] x);
        return x >>> QUANT_BITS;
    endfunction

endpackage

// File: rtl/fm_demod_div.sv
// Iterative signed restoring divider: one quotient bit per cycle, quotient truncated toward zero.
module fm_demod_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             done,
    output logic [WIDTH-1:0] quot
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] den_mag;
    logic             neg;
    logic [WIDTH:0]   rem_sh;
    logic             ge;

    // Magnitudes are unsigned, so the most negative operand still has a representable magnitude.
    assign rem_sh = {rem, q_r[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, den_mag};
    assign done   = busy && (cnt == '0);
    assign quot   = neg ? -q_r : q_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            q_r     <= '0;
            rem     <= '0;
            den_mag <= '0;
            neg     <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= CNT_W'(WIDTH);
            q_r     <= num[WIDTH-1] ? -num : num;
            rem     <= '0;
            den_mag <= den[WIDTH-1] ? -den : den;
            neg     <= num[WIDTH-1] ^ den[WIDTH-1];
        end else if (busy) begin
            if (cnt != '0) begin
                rem <= WIDTH'(ge ? rem_sh - {1'b0, den_mag} : rem_sh);
                q_r <= {q_r[WIDTH-2:0], ge};
                cnt <= cnt - 1'b1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fm_demod.sv
// Quadrature FM discriminator: conj-multiply against the previous sample, qarctan, gain, push.
//  state     | meaning
//  READ      | wait for both I and Q FIFOs non-empty, pop one pair
//  CONJ      | cur * conj(prev) -> re/im, shift cur into prev
//  DIV_START | form qarctan numerator/denominator, start divider
//  DIV_WAIT  | wait for divider done
//  ANGLE     | quadrant correction and gain -> y_r
//  WRITE     | present y_r, push when output FIFO not full
module fm_demod
    import fm_demod_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MULT_WIDTH = 64,
    parameter int FM_GAIN    = FM_GAIN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_empty,
    output logic                  i_in_rd_en,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic                  q_in_empty,
    output logic                  q_in_rd_en,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic                  y_out_full,
    output logic                  y_out_wr_en,
    output logic [DATA_WIDTH-1:0] y_out
);

    localparam int DW = DATA_WIDTH;
    localparam int MW = MULT_WIDTH;

    fm_demod_state_t state, state_nxt;

    logic signed [DW-1:0] cur_i, cur_q, prev_i, prev_q, re_r, im_r, y_r;
    logic signed [DW-1:0] re_nxt, im_nxt, abs_y, num, den, quot, ang_pos, ang, y_nxt;
    logic signed [MW-1:0] p_ii, p_qq, p_iq, p_qi, prod_q, prod_y;
    logic                 div_start, div_done;

    assign p_ii   = MW'(cur_i) * MW'(prev_i);
    assign p_qq   = MW'(cur_q) * MW'(prev_q);
    assign p_iq   = MW'(prev_i) * MW'(cur_q);
    assign p_qi   = MW'(prev_q) * MW'(cur_i);
    assign re_nxt = DW'(dequantize_i(64'(p_ii + p_qq)));
    assign im_nxt = DW'(dequantize_i(64'(p_iq - p_qi)));

    // abs_y is |im|+1, so den can never reach zero.
    always_comb begin
        abs_y = (im_r[DW-1] ? -im_r : im_r) + DW'(1);
        num   = '0;
        den   = '0;
        if (!re_r[DW-1]) begin
            num = DW'(quantize_i(64'(re_r - abs_y)));
            den = re_r + abs_y;
        end else begin
            num = DW'(quantize_i(64'(re_r + abs_y)));
            den = abs_y - re_r;
        end
    end

    assign prod_q  = MW'(quot) * MW'(QUAD1);
    assign ang_pos = (re_r[DW-1] ? DW'(QUAD3) : DW'(QUAD1)) - DW'(dequantize_i(64'(prod_q)));
    assign ang     = im_r[DW-1] ? -ang_pos : ang_pos;
    assign prod_y  = MW'(ang) * MW'(FM_GAIN);
    assign y_nxt   = DW'(dequantize_i(64'(prod_y)));

    fm_demod_div #(.WIDTH(DW)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (num),
        .den   (den),
        .done  (div_done),
        .quot  (quot)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= READ;
            cur_i  <= '0;
            cur_q  <= '0;
            prev_i <= '0;
            prev_q <= '0;
            re_r   <= '0;
            im_r   <= '0;
            y_r    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                READ: if (i_in_rd_en) begin
                    cur_i <= i_in;
                    cur_q <= q_in;
                end
                CONJ: begin
                    re_r   <= re_nxt;
                    im_r   <= im_nxt;
                    prev_i <= cur_i;
                    prev_q <= cur_q;
                end
                ANGLE:   y_r <= y_nxt;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        i_in_rd_en  = 1'b0;
        q_in_rd_en  = 1'b0;
        y_out_wr_en = 1'b0;
        y_out       = '0;
        div_start   = 1'b0;
        case (state)
            READ: if (!i_in_empty && !q_in_empty) begin
                i_in_rd_en = 1'b1;
                q_in_rd_en = 1'b1;
                state_nxt  = CONJ;
            end
            CONJ:      state_nxt = DIV_START;
            DIV_START: begin
                div_start = 1'b1;
                state_nxt = DIV_WAIT;
            end
            DIV_WAIT:  if (div_done) state_nxt = ANGLE;
            ANGLE:     state_nxt = WRITE;
            WRITE: begin
                y_out = y_r;
                if (!y_out_full) begin
                    y_out_wr_en = 1'b1;
                    state_nxt   = READ;
                end
            end
            default:   state_nxt = READ;
        endcase
        // Outputs are quiet for the whole reset cycle, whatever state is registered.
        if (!rst) begin
            i_in_rd_en  = 1'b0;
            q_in_rd_en  = 1'b0;
            y_out_wr_en = 1'b0;
            y_out       = '0;
        end
    end

endmodule

// File: tb/tb_fm_demod.sv
// Bench for fm_demod: FIFO-modelled stimulus, directed cases and randomized samples vs a qarctan model.
module tb_fm_demod;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_in_empty = 1'b1;
    logic          q_in_empty = 1'b1;
    logic [DW-1:0] i_in = '0;
    logic [DW-1:0] q_in = '0;
    logic          y_out_full = 1'b0;
    logic          i_in_rd_en, q_in_rd_en, y_out_wr_en;
    logic [DW-1:0] y_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int proto_viol = 0;
    int last_y = 0;
    logic last_wr = 1'b0;
    int iq[$], qq[$], outq[$], pop_cyc[$], push_cyc[$];
    int mp_i = 0, mp_q = 0;

    fm_demod dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_empty  (i_in_empty),
        .i_in_rd_en  (i_in_rd_en),
        .i_in        (i_in),
        .q_in_empty  (q_in_empty),
        .q_in_rd_en  (q_in_rd_en),
        .q_in        (q_in),
        .y_out_full  (y_out_full),
        .y_out_wr_en (y_out_wr_en),
        .y_out       (y_out)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference: cur * conj(prev), qarctan with quadrant correction, gain; all at 64-bit then truncated.
    function automatic int model_demod(int ci, int cq);
        int re, im, ay, num, den, quot, ang;
        re = int'((longint'(ci) * mp_i + longint'(cq) * mp_q) >>> 10);
        im = int'((longint'(mp_i) * cq - longint'(mp_q) * ci) >>> 10);
        mp_i = ci;
        mp_q = cq;
        ay = (im < 0 ? -im : im) + 1;
        if (re >= 0) begin
            num = (re - ay) <<< 10;
            den = re + ay;
        end else begin
            num = (re + ay) <<< 10;
            den = ay - re;
        end
        quot = num / den;
        ang = (re >= 0 ? 804 : 2412) - int'((longint'(804) * quot) >>> 10);
        if (im < 0) ang = -ang;
        return int'((longint'(758) * ang) >>> 10);
    endfunction

    // One clock: present FIFO heads, sample DUT mid-cycle, apply pops/pushes, advance to next negedge.
    task automatic step();
        i_in_empty = (iq.size() == 0);
        q_in_empty = (qq.size() == 0);
        i_in = i_in_empty ? '0 : iq[0];
        q_in = q_in_empty ? '0 : qq[0];
        #1;
        last_y  = y_out;
        last_wr = y_out_wr_en;
        if ((i_in_rd_en !== q_in_rd_en) || (i_in_rd_en && y_out_wr_en) || (y_out_wr_en && y_out_full))
            proto_viol++;
        if (i_in_rd_en === 1'b1) begin
            if (iq.size() == 0 || qq.size() == 0) proto_viol++;
            else begin
                void'(iq.pop_front());
                void'(qq.pop_front());
                pop_cyc.push_back(cyc);
            end
        end
        if (y_out_wr_en === 1'b1) begin
            outq.push_back(int'(y_out));
            push_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_for(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_outputs(int n, int budget);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            step();
            k++;
        end
        if (outq.size() < n) begin
            errors++;
            $display("FAIL wait_outputs: got %0d outputs, required %0d within %0d cycles", outq.size(), n, budget);
        end
    endtask

    task automatic test_reset();
        iq.push_back(1024);
        qq.push_back(0);
        rst = 1'b0;
        run_for(4);
        checks++;
        if (iq.size() !== 1) begin
            errors++;
            $display("FAIL reset_no_pop: fifo depth %0d, required 1", iq.size());
        end
        checks++;
        if (last_y !== 0 || last_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: y_out=%0d wr_en=%b, required 0/0", last_y, last_wr);
        end
        iq.delete();
        qq.delete();
        rst = 1'b1;
        mp_i = 0;
        mp_q = 0;
        run_for(3);
        checks++;
        if (outq.size() !== 0 || last_y !== 0) begin
            errors++;
            $display("FAIL reset_idle: outputs=%0d y_out=%0d, required 0/0", outq.size(), last_y);
        end
    endtask

    task automatic test_known();
        int ci[4] = '{1024, 1024, 0, 1024};
        int cq[4] = '{0, 0, 1024, 0};
        int expv[4] = '{1190, 1, 1190, -1191};
        int got;
        pop_cyc.delete();
        push_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            iq.push_back(ci[k]);
            qq.push_back(cq[k]);
        end
        wait_outputs(4, 200);
        for (int k = 0; k < 4; k++) begin
            void'(model_demod(ci[k], cq[k]));
            checks++;
            got = (outq.size() > 0) ? outq.pop_front() : 32'h7fffffff;
            if (got !== expv[k]) begin
                errors++;
                $display("FAIL known_%0d: y_out=%0d, required %0d", k, got, expv[k]);
            end
        end
        checks++;
        if (push_cyc.size() < 1 || pop_cyc.size() < 2 || push_cyc[0] - pop_cyc[0] !== DW + 5) begin
            errors++;
            $display("FAIL latency: pop->push=%0d, required %0d",
                     (push_cyc.size() > 0 && pop_cyc.size() > 0) ? push_cyc[0] - pop_cyc[0] : -1, DW + 5);
        end
        checks++;
        if (pop_cyc.size() < 2 || pop_cyc[1] - pop_cyc[0] !== DW + 6) begin
            errors++;
            $display("FAIL throughput: pop spacing=%0d, required %0d",
                     pop_cyc.size() > 1 ? pop_cyc[1] - pop_cyc[0] : -1, DW + 6);
        end
    endtask

    task automatic test_full();
        int a, b, e1, e2, got, bad;
        a = $urandom_range(0, 4000) - 2000;
        b = $urandom_range(0, 4000) - 2000;
        e1 = model_demod(a, b);
        iq.push_back(a);
        qq.push_back(b);
        iq.push_back(500);
        qq.push_back(-300);
        y_out_full = 1'b1;
        step();
        run_for(DW + 5);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (last_y !== e1 || last_wr !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_hold: %0d bad cycles, last y_out=%0d, required %0d held", bad, last_y, e1);
        end
        checks++;
        if (outq.size() !== 0 || iq.size() !== 1) begin
            errors++;
            $display("FAIL full_stall: pushes=%0d fifo depth=%0d, required 0/1", outq.size(), iq.size());
        end
        y_out_full = 1'b0;
        run_for(2);
        checks++;
        got = (outq.size() > 0) ? outq[0] : 32'h7fffffff;
        if (outq.size() !== 1 || got !== e1) begin
            errors++;
            $display("FAIL full_release: pushes=%0d y=%0d, required 1 push of %0d", outq.size(), got, e1);
        end
        outq.delete();
        e2 = model_demod(500, -300);
        wait_outputs(1, 100);
        checks++;
        got = (outq.size() > 0) ? outq.pop_front() : 32'h7fffffff;
        if (got !== e2) begin
            errors++;
            $display("FAIL full_next: y_out=%0d, required %0d", got, e2);
        end
    endtask

    task automatic test_empty();
        int e, got, npop;
        npop = pop_cyc.size();
        iq.push_back(-1500);
        run_for(20);
        checks++;
        if (iq.size() !== 1 || pop_cyc.size() !== npop) begin
            errors++;
            $display("FAIL q_empty_no_pop: pops=%0d, required 0", pop_cyc.size() - npop);
        end
        qq.push_back(900);
        step();
        checks++;
        if (iq.size() !== 0 || qq.size() !== 0 || pop_cyc.size() !== npop + 1) begin
            errors++;
            $display("FAIL pair_pop: i depth=%0d q depth=%0d, required 0/0", iq.size(), qq.size());
        end
        e = model_demod(-1500, 900);
        wait_outputs(1, 100);
        checks++;
        got = (outq.size() > 0) ? outq.pop_front() : 32'h7fffffff;
        if (got !== e) begin
            errors++;
            $display("FAIL empty_result: y_out=%0d, required %0d", got, e);
        end
    endtask

    task automatic test_reset_mid();
        int got;
        iq.push_back(2000);
        qq.push_back(-700);
        step();
        run_for(10);
        rst = 1'b0;
        run_for(2);
        rst = 1'b1;
        mp_i = 0;
        mp_q = 0;
        run_for(45);
        checks++;
        if (outq.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid_discard: pushes=%0d, required 0", outq.size());
            outq.delete();
        end
        iq.push_back(1024);
        qq.push_back(0);
        void'(model_demod(1024, 0));
        wait_outputs(1, 100);
        checks++;
        got = (outq.size() > 0) ? outq.pop_front() : 32'h7fffffff;
        if (got !== 1190) begin
            errors++;
            $display("FAIL reset_mid_prev0: y_out=%0d, required 1190", got);
        end
    endtask

    task automatic test_random(int n);
        int a, b, e, got, nbad;
        nbad = 0;
        for (int s = 0; s < n; s++) begin
            a = $urandom_range(0, 8000) - 4000;
            b = $urandom_range(0, 8000) - 4000;
            e = model_demod(a, b);
            iq.push_back(a);
            if ($urandom_range(0, 3) == 0) run_for($urandom_range(1, 4));
            qq.push_back(b);
            if ($urandom_range(0, 7) == 0) begin
                y_out_full = 1'b1;
                run_for($urandom_range(DW + 2, DW + 12));
                y_out_full = 1'b0;
            end
            wait_outputs(1, 200);
            checks++;
            got = (outq.size() > 0) ? outq.pop_front() : 32'h7fffffff;
            if (got !== e) begin
                errors++;
                nbad++;
                if (nbad <= 10)
                    $display("FAIL random_%0d: I=%0d Q=%0d y_out=%0d, required %0d", s, a, b, got, e);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_known();
        test_full();
        test_empty();
        test_reset_mid();
        test_random(1000);
        checks++;
        if (proto_viol !== 0) begin
            errors++;
            $display("FAIL handshake: %0d protocol violations, required 0", proto_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
